// File: rtl/vga_text_pkg.sv
// Shared constants, control codes and FSM state type for the text console path.
package vga_text_pkg;

    localparam int unsigned N_COL           = 80;
    localparam int unsigned N_ROW           = 30;
    localparam int unsigned COL_WIDTH       = 7;
    localparam int unsigned ROW_WIDTH       = 5;
    localparam int unsigned CELL_ADDR_WIDTH = 12;

    localparam logic [7:0] CHR_BS         = 8'h08;
    localparam logic [7:0] CHR_LF         = 8'h0A;
    localparam logic [7:0] CHR_FF         = 8'h0C;
    localparam logic [7:0] CHR_CR         = 8'h0D;
    localparam logic [7:0] CHR_PRINT_LO   = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI   = 8'h7E;
    localparam logic [7:0] FILL_CHAR      = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLEAR_ROW,
        ST_CLEAR_ALL
    } state_e;

    // row * 80 as shift-and-add so no multiplier is inferred.
    function automatic logic [CELL_ADDR_WIDTH-1:0] row_base(input logic [ROW_WIDTH-1:0] row);
        logic [CELL_ADDR_WIDTH-1:0] r;
        r = {{(CELL_ADDR_WIDTH-ROW_WIDTH){1'b0}}, row};
        return (r << 6) + (r << 4);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-stream input and character-buffer write port of the text console.
interface text_console_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CHAR_WIDTH = 8
);
    logic                  char_valid;
    logic [CHAR_WIDTH-1:0] char_data;
    logic                  char_ready;
    logic                  wr_req;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CHAR_WIDTH-1:0] wr_data;

    modport master (
        input  char_valid, char_data, wr_ready,
        output char_ready, wr_req, wr_addr, wr_data
    );

    modport slave (
        output char_valid, char_data, wr_ready,
        input  char_ready, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/text_cell_addr.sv
// Maps a (scroll, logical row, column) cursor to its physical row and cell index.
module text_cell_addr
    import vga_text_pkg::*;
#(
    parameter int unsigned N_ROW = vga_text_pkg::N_ROW
) (
    input  logic [ROW_WIDTH-1:0]       scroll_row,
    input  logic [ROW_WIDTH-1:0]       log_row,
    input  logic [COL_WIDTH-1:0]       col,
    output logic [ROW_WIDTH-1:0]       phys_row,
    output logic [CELL_ADDR_WIDTH-1:0] cell_addr
);
    logic [ROW_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, scroll_row} + {1'b0, log_row};
        if (sum >= (ROW_WIDTH+1)'(N_ROW))
            sum = sum - (ROW_WIDTH+1)'(N_ROW);
        phys_row  = sum[ROW_WIDTH-1:0];
        cell_addr = row_base(phys_row) + CELL_ADDR_WIDTH'(col);
    end
endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style byte sequencer: cursor tracking, control codes, hardware scroll
// with recycled-row clear, and full-screen clear onto the character buffer write port.
module text_console_ctrl
    import vga_text_pkg::*;
#(
    parameter int unsigned           N_COL      = vga_text_pkg::N_COL,
    parameter int unsigned           N_ROW      = vga_text_pkg::N_ROW,
    parameter int unsigned           ADDR_WIDTH = vga_text_pkg::CELL_ADDR_WIDTH,
    parameter int unsigned           CHAR_WIDTH = 8,
    parameter logic [CHAR_WIDTH-1:0] FILL_CHAR  = CHAR_WIDTH'(vga_text_pkg::FILL_CHAR)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    text_console_ctrl_if.master  bus,
    output logic [COL_WIDTH-1:0] cursor_col_o,
    output logic [ROW_WIDTH-1:0] cursor_row_o,
    output logic [ROW_WIDTH-1:0] scroll_row_o,
    output logic                 busy_o
);
    state_e                     state_q, nxt_state;
    logic [COL_WIDTH-1:0]       col_q, nxt_col;
    logic [ROW_WIDTH-1:0]       log_q, nxt_log;
    logic [ROW_WIDTH-1:0]       scroll_q, nxt_scroll;
    logic [ROW_WIDTH-1:0]       phys_q, nxt_phys;
    logic [CELL_ADDR_WIDTH-1:0] cell_q, nxt_cell;
    logic                       req_q, nxt_req;
    logic [ADDR_WIDTH-1:0]      addr_q, nxt_addr;
    logic [CHAR_WIDTH-1:0]      data_q, nxt_data;
    logic [ADDR_WIDTH-1:0]      cnt_q, nxt_cnt;
    logic                       adv_q, nxt_adv;
    logic                       pend_q, nxt_pend;
    logic                       busy_q;
    logic                       accept, hs, newline;

    assign bus.char_ready = (state_q == ST_IDLE) && !pend_q && !clear_i;
    assign accept         = bus.char_ready && bus.char_valid;
    assign hs             = req_q && bus.wr_ready;

    // Cursor cell and physical row are precomputed from next-state values so
    // both land in registers alongside the cursor itself.
    text_cell_addr #(.N_ROW(N_ROW)) u_cell_addr (
        .scroll_row (nxt_scroll),
        .log_row    (nxt_log),
        .col        (nxt_col),
        .phys_row   (nxt_phys),
        .cell_addr  (nxt_cell)
    );

    always_comb begin
        nxt_state  = state_q;
        nxt_col    = col_q;
        nxt_log    = log_q;
        nxt_scroll = scroll_q;
        nxt_req    = req_q;
        nxt_addr   = addr_q;
        nxt_data   = data_q;
        nxt_cnt    = cnt_q;
        nxt_adv    = adv_q;
        nxt_pend   = pend_q;
        newline    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_i || pend_q ||
                    (accept && bus.char_data == CHAR_WIDTH'(CHR_FF))) begin
                    nxt_state = ST_CLEAR_ALL;
                    nxt_req   = 1'b1;
                    nxt_addr  = '0;
                    nxt_data  = FILL_CHAR;
                    nxt_cnt   = '0;
                    nxt_pend  = 1'b0;
                end else if (accept) begin
                    if (bus.char_data >= CHAR_WIDTH'(CHR_PRINT_LO) &&
                        bus.char_data <= CHAR_WIDTH'(CHR_PRINT_HI)) begin
                        nxt_state = ST_PUT;
                        nxt_req   = 1'b1;
                        nxt_addr  = ADDR_WIDTH'(cell_q);
                        nxt_data  = bus.char_data;
                        nxt_adv   = 1'b1;
                    end else if (bus.char_data == CHAR_WIDTH'(CHR_CR)) begin
                        nxt_col = '0;
                    end else if (bus.char_data == CHAR_WIDTH'(CHR_LF)) begin
                        nxt_col = '0;
                        newline = 1'b1;
                    end else if (bus.char_data == CHAR_WIDTH'(CHR_BS) && col_q != '0) begin
                        nxt_col   = col_q - COL_WIDTH'(1);
                        nxt_state = ST_PUT;
                        nxt_req   = 1'b1;
                        nxt_addr  = ADDR_WIDTH'(cell_q - CELL_ADDR_WIDTH'(1));
                        nxt_data  = FILL_CHAR;
                        nxt_adv   = 1'b0;
                    end
                end
            end
            ST_PUT: begin
                if (clear_i) nxt_pend = 1'b1;
                if (hs) begin
                    nxt_req   = 1'b0;
                    nxt_state = ST_IDLE;
                    if (adv_q) begin
                        if (col_q == COL_WIDTH'(N_COL - 1)) begin
                            nxt_col = '0;
                            newline = 1'b1;
                        end else begin
                            nxt_col = col_q + COL_WIDTH'(1);
                        end
                    end
                end
            end
            ST_CLEAR_ROW: begin
                if (clear_i) nxt_pend = 1'b1;
                if (hs) begin
                    if (cnt_q == ADDR_WIDTH'(N_COL - 1)) begin
                        nxt_req   = 1'b0;
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_cnt  = cnt_q + ADDR_WIDTH'(1);
                        nxt_addr = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_CLEAR_ALL: begin
                if (hs) begin
                    if (cnt_q == ADDR_WIDTH'(N_COL * N_ROW - 1)) begin
                        nxt_req    = 1'b0;
                        nxt_state  = ST_IDLE;
                        nxt_col    = '0;
                        nxt_log    = '0;
                        nxt_scroll = '0;
                    end else begin
                        nxt_cnt  = cnt_q + ADDR_WIDTH'(1);
                        nxt_addr = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Bottom-row newline scrolls: the row leaving the top is recycled as the new bottom.
        if (newline) begin
            if (log_q < ROW_WIDTH'(N_ROW - 1)) begin
                nxt_log = log_q + ROW_WIDTH'(1);
            end else begin
                nxt_scroll = (scroll_q == ROW_WIDTH'(N_ROW - 1)) ? '0 : scroll_q + ROW_WIDTH'(1);
                nxt_state  = ST_CLEAR_ROW;
                nxt_req    = 1'b1;
                nxt_addr   = ADDR_WIDTH'(row_base(scroll_q));
                nxt_data   = FILL_CHAR;
                nxt_cnt    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            log_q    <= '0;
            scroll_q <= '0;
            phys_q   <= '0;
            cell_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            adv_q    <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= nxt_state;
            col_q    <= nxt_col;
            log_q    <= nxt_log;
            scroll_q <= nxt_scroll;
            phys_q   <= nxt_phys;
            cell_q   <= nxt_cell;
            req_q    <= nxt_req;
            addr_q   <= nxt_addr;
            data_q   <= nxt_data;
            cnt_q    <= nxt_cnt;
            adv_q    <= nxt_adv;
            pend_q   <= nxt_pend;
            busy_q   <= (nxt_state != ST_IDLE);
        end
    end

    assign bus.wr_req   = req_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign cursor_col_o = col_q;
    assign cursor_row_o = phys_q;
    assign scroll_row_o = scroll_q;
    assign busy_o       = busy_q;
endmodule
